// File: rtl/gpio_in.sv
// Memory-mapped GPIO input block: synchronised, debounced pins with sticky W1C edge flags.
// Define GPIO_IN_IRQ_EN to implement the MASK register and the level irq output.
`ifndef WORDSIZE
`define WORDSIZE 31:0
`endif

module gpio_in #(
  parameter int          WIDTH           = 4,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0100
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_pins,
  input  logic [`WORDSIZE] addr,
  input  logic [`WORDSIZE] wdata,
  input  logic             we,
  output logic             hit,
  output logic [`WORDSIZE] rdata,
  output logic             irq
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_RISE = 2'd1,
    REG_FALL = 2'd2,
    REG_MASK = 2'd3
  } reg_sel_e;

  logic [WIDTH-1:0] r_s1, r_s2, r_stable, r_rise, r_fall;
  logic [CW-1:0]    r_cnt [WIDTH];

  logic [31:0]      w_offset;
  reg_sel_e         w_sel;
  logic             w_wr;
  logic [WIDTH-1:0] w_stable_nxt, w_rise_set, w_fall_set, w_rise_clr, w_fall_clr;
  logic [CW-1:0]    w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_mask;
  logic             w_unused;

  // Offset below BASE_ADDR wraps to a large value, so one compare bounds both ends.
  assign w_offset = addr - BASE_ADDR;
  assign w_sel    = reg_sel_e'(w_offset[3:2]);
  assign hit      = (addr[1:0] == 2'b00) && (w_offset < 32'h10);
  assign w_wr     = hit && we && reset;
  assign w_unused = ^wdata;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_stable_nxt = r_stable;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_s2[i] != r_stable[i]) begin
        if (r_cnt[i] == CNT_LAST) w_stable_nxt[i] = r_s2[i];
        else                      w_cnt_nxt[i]    = r_cnt[i] + 1'b1;
      end
    end
  end

  assign w_rise_set = w_stable_nxt & ~r_stable;
  assign w_fall_set = ~w_stable_nxt & r_stable;
  assign w_rise_clr = (w_wr && w_sel == REG_RISE) ? wdata[WIDTH-1:0] : '0;
  assign w_fall_clr = (w_wr && w_sel == REG_FALL) ? wdata[WIDTH-1:0] : '0;

  // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_stable <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      // NOTE: the counter array is small flop storage, not RAM, so it is reset like any register.
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_s1     <= in_pins;
      r_s2     <= r_s1;
      r_stable <= w_stable_nxt;
      r_rise   <= (r_rise & ~w_rise_clr) | w_rise_set;
      r_fall   <= (r_fall & ~w_fall_clr) | w_fall_set;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

`ifdef GPIO_IN_IRQ_EN
  logic [WIDTH-1:0] r_mask;
  logic             r_irq;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr && w_sel == REG_MASK) r_mask <= wdata[WIDTH-1:0];
      r_irq <= |(r_rise & r_mask);
    end
  end

  assign w_mask = r_mask;
  assign irq    = r_irq;
`else
  assign w_mask = '0;
  assign irq    = 1'b0;
`endif

  // Gated by reset so reads during reset show cleared state even before the first edge.
  always_comb begin
    rdata = '0;
    if (hit && reset) begin
      case (w_sel)
        REG_DATA: rdata[WIDTH-1:0] = r_stable;
        REG_RISE: rdata[WIDTH-1:0] = r_rise;
        REG_FALL: rdata[WIDTH-1:0] = r_fall;
        REG_MASK: rdata[WIDTH-1:0] = w_mask;
      endcase
    end
  end

endmodule
